seq_chunk_adder: RTL and testbench

//   Multi-cycle unsigned adder: adds two WIDTH-bit operands CHUNK bits per clock.

---
 rtl/seq_chunk_adder_pkg.sv | 29 ++
 rtl/seq_chunk_adder_chunk_ripple_add.sv | 33 +++
 rtl/seq_chunk_adder.sv | 150 +++++++++++++++
 tb/tb_seq_chunk_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_chunk_adder_pkg
//  Description : Shared types and helpers for the chunk-serial adder.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_chunk_adder_pkg;

    // Controller states: accept operands, add chunk by chunk, present result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of one bit, for sizing the chunk index
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chunk_adder_chunk_ripple_add.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_ripple_add
//  Description : Combinational CHUNK-bit ripple-carry adder built from
//                full-adder cells.
//  Revision    : 1.0  initial release
// ============================================================================
module chunk_ripple_add #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit, carry rippling upward
    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa
            assign s[i]   = x[i] ^ y[i] ^ c[i];
            assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    endgenerate

    assign cout = c[CHUNK];

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : seq_chunk_adder
//  Description : Multi-cycle unsigned adder processing CHUNK bits per clock
//                with valid/ready handshakes on input and output.
//                Optional macro SEQ_CHUNK_ADDER_SUB_EN adds a 'sub' port that
//                selects a + ~b + 1.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int K    = WIDTH / CHUNK;
    localparam int IDXW = clog2(K);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    // Reject configurations the chunk slicing cannot represent
    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH:0]    sum_reg;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              sub_sel;
    logic              capture;
    logic              last_chunk;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Select the operand chunk currently being added
    always_comb begin
        a_chunk = op_a[int'(idx) * CHUNK +: CHUNK];
        b_chunk = op_b[int'(idx) * CHUNK +: CHUNK];
    end

    chunk_ripple_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .x    (a_chunk),
        .y    (b_chunk),
        .cin  (carry),
        .s    (chunk_sum),
        .cout (chunk_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        capture    = 1'b0;
        last_chunk = (idx == LAST_IDX);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE first keeps acceptance and capture in
                // separate cycles.
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, chunk accumulation, carry and index bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
        end else if (capture) begin
            op_a  <= a;
            // Subtraction is a + ~b + 1: invert b now, seed the carry with 1
            op_b  <= sub_sel ? ~b : b;
            carry <= sub_sel;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg[int'(idx) * CHUNK +: CHUNK] <= chunk_sum;
            carry <= chunk_cout;
            if (last_chunk) begin
                sum_reg[WIDTH] <= chunk_cout;
                idx            <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum = sum_reg;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_chunk_adder
//  Description : Self-checking bench for seq_chunk_adder (WIDTH=8, CHUNK=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_chunk_adder;

    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int K     = WIDTH / CHUNK;
    localparam int BOUND = 40;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;

    int checks;
    int errors;

    logic [WIDTH:0] sb[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH:0]   exp;
    } vec_t;

    vec_t vecs[8];

    seq_chunk_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Wait for the result, check latency and value, optionally accept it
    task automatic wait_result(input string nm, input bit take);
        int cyc;
        logic [WIDTH:0] exp;
        cyc = 0;
        while (!out_valid && cyc < BOUND) begin
            check({nm, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_latency"}, 32'(cyc), 32'(K));
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({nm, "_sum"}, 32'(sum), 32'(exp));
        check({nm, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({nm, "_out_valid_after"}, 32'(out_valid), 32'd0);
            check({nm, "_in_ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    // Present operands in IDLE and push the expected result on acceptance
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic ts, input logic [WIDTH:0] exp);
        a        = ta;
        b        = tb_;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub      = ts;
`else
        if (ts) $display("note: subtract vector issued without subtract build");
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(exp);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub       = 1'b0;
`endif

        vecs[0] = '{8'h12, 8'h34, 1'b0, 9'h046};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 9'h010};
        vecs[7] = '{8'h7F, 8'h81, 1'b0, 9'h100};

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec%0d_in_ready_idle", i), 32'(in_ready), 32'd1);
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp);
            wait_result($sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: result held while stalled, input pulses ignored
        issue(8'h3C, 8'h0F, 1'b0, 9'h04B);
        wait_result("bp", 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 8'hAA;
            b        = 8'h55;
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_sum", i), 32'(sum), 32'h04B);
            check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        // Accept the result with new operands already waiting: no capture yet
        in_valid  = 1'b1;
        a         = 8'h01;
        b         = 8'h02;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_accept_out_valid", 32'(out_valid), 32'd0);
        check("bp_accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(9'h003);
        check("bp_next_captured", 32'(in_ready), 32'd0);
        wait_result("bp_next", 1'b1);

        // Reset two cycles after acceptance aborts the operation
        issue(8'hC3, 8'h5A, 1'b0, 9'h11D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sum", 32'(sum), 32'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'h01, 8'h01, 1'b0, 9'h002);
        wait_result("post_abort", 1'b1);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        issue(8'd5, 8'd3, 1'b1, 9'h102);
        wait_result("sub_5_3", 1'b1);
        issue(8'd3, 8'd5, 1'b1, 9'h0FE);
        wait_result("sub_3_5", 1'b1);
        issue(8'd0, 8'd0, 1'b1, 9'h100);
        wait_result("sub_0_0", 1'b1);
        sub = 1'b0;
`endif

        // Random pairs against the modulo-2^(WIDTH+1) sum
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, 1'b0, {1'b0, ra} + {1'b0, rb});
            wait_result($sformatf("rnd%0d", i), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
